// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks in-flight destination registers and picks the
// youngest ready producer per decode source, stalling on results not yet available.
module fwd_scoreboard #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned LAT_W   = 2,
  parameter int unsigned SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       issue_valid,
  input  logic [4:0]                 issue_rd,
  input  logic                       issue_reg_write,
  input  logic [LAT_W-1:0]           issue_lat,
  input  logic [NUM_SRC*5-1:0]       src_addr,
  input  logic [NUM_SRC-1:0]         src_used,
  input  logic                       hold,
  input  logic                       flush,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic                       stall,
  output logic [15:0]                stall_count
);

  localparam int unsigned RD_W  = 5;
  localparam int unsigned CNT_W = 16;

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] rw_q, rw_d;
  logic [RD_W-1:0]  rd_q  [DEPTH];
  logic [RD_W-1:0]  rd_d  [DEPTH];
  logic [LAT_W-1:0] lat_q [DEPTH];
  logic [LAT_W-1:0] lat_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_SRC-1:0] not_rdy;
  logic [NUM_SRC-1:0] found;
  logic               load;

  // Youngest matching entry wins; a winner still counting down blocks issue.
  always_comb begin
    fwd_sel = '0;
    not_rdy = '0;
    found   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (!found[i] && src_used[i] && vld_q[k] && rw_q[k] &&
            (rd_q[k] != '0) && (rd_q[k] == src_addr[i*RD_W +: RD_W])) begin
          found[i] = 1'b1;
          if (lat_q[k] == '0) begin
            fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
          end else begin
            not_rdy[i] = 1'b1;
          end
        end
      end
    end
    stall = issue_valid && !flush && (|not_rdy);
  end

  // Pipeline advance: shift entries, age latencies, insert issue or bubble.
  always_comb begin
    vld_d = vld_q;
    rw_d  = rw_q;
    rd_d  = rd_q;
    lat_d = lat_q;
    cnt_d = cnt_q;
    load  = issue_valid && !stall && !flush;
    if (!hold) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        vld_d[k] = vld_q[k-1];
        rw_d[k]  = rw_q[k-1];
        rd_d[k]  = rd_q[k-1];
        lat_d[k] = (lat_q[k-1] == '0) ? '0 : lat_q[k-1] - LAT_W'(1);
      end
      vld_d[0] = load;
      rw_d[0]  = load && issue_reg_write;
      rd_d[0]  = load ? issue_rd : '0;
      lat_d[0] = load ? issue_lat : '0;
      if (stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      rw_q  <= '0;
      cnt_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        rd_q[k]  <= '0;
        lat_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      rw_q  <= rw_d;
      cnt_q <= cnt_d;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        rd_q[k]  <= rd_d[k];
        lat_q[k] <= lat_d[k];
      end
    end
  end

  assign stall_count = cnt_q;

endmodule
